// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function for the 4-way mux arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // First set request at ptr, ptr+1, ptr+2, ptr+3 (mod 4). Scanning downward
   // lets the lowest offset overwrite the others.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
      pick_t      p;
      logic [1:0] k;
      p = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = ptr + 2'(i);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4_bus.sv
// Combinational 4:1 data mux, zero latency, no flow control of its own.
module mux4_bus #(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] in0_data,
   input  logic [WIDTH-1:0] in1_data,
   input  logic [WIDTH-1:0] in2_data,
   input  logic [WIDTH-1:0] in3_data,
   output logic [WIDTH-1:0] out_data
);

   always_comb begin
      out_data = in0_data;
      case (sel)
         2'd0:    out_data = in0_data;
         2'd1:    out_data = in1_data;
         2'd2:    out_data = in2_data;
         default: out_data = in3_data;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grant in the cycle after req from idle, zero-bubble handover.
// Grant is held while the output is stalled; it rotates after MAX_BURST beats or when req[sel] drops.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in0_data,
   input  logic [WIDTH-1:0] in1_data,
   input  logic [WIDTH-1:0] in2_data,
   input  logic [WIDTH-1:0] in3_data,
   output logic [3:0]       in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       grant,
   output logic [1:0]       sel
);

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t           state;
   logic [1:0]       ptr;
   logic [7:0]       cnt;
   logic             busy;
   logic             beat;
   logic             rel;
   logic [1:0]       nxt_ptr;
   pick_t            pick_idle;
   pick_t            pick_rel;
   logic [WIDTH-1:0] mux_out;

   mux4_bus #(.WIDTH(WIDTH)) u_bus (
      .sel      (sel),
      .in0_data (in0_data),
      .in1_data (in1_data),
      .in2_data (in2_data),
      .in3_data (in3_data),
      .out_data (mux_out)
   );

   assign busy      = (state == BUSY);
   assign out_valid = busy & req[sel];
   assign out_data  = busy ? mux_out : '0;
   assign in_ready  = grant & {N_REQ{out_ready}};
   assign beat      = out_valid & out_ready;
   // Burst exhausted, or the owner withdrew without a beat this cycle.
   assign rel       = busy & ((beat && (cnt == LAST_BEAT)) || !req[sel]);
   assign nxt_ptr   = sel + 2'd1;
   assign pick_idle = rr_pick(req, ptr);
   assign pick_rel  = rr_pick(req, nxt_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 2'd0;
         grant <= 4'b0000;
         ptr   <= 2'd0;
         cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               grant <= 4'b0000;
               if (pick_idle.found) begin
                  sel   <= pick_idle.idx;
                  grant <= 4'b0001 << pick_idle.idx;
                  cnt   <= 8'd0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (rel) begin
                  ptr <= nxt_ptr;
                  cnt <= 8'd0;
                  if (pick_rel.found) begin
                     sel   <= pick_rel.idx;
                     grant <= 4'b0001 << pick_rel.idx;
                  end else begin
                     grant <= 4'b0000;
                     state <= IDLE;
                  end
               end else if (beat) begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Table-driven bench for mux4_rr_arbiter with a data scoreboard and an async-reset corner sequence.
module tb_mux4_rr_arbiter;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [3:0] req;
      logic       rdy;
      logic [3:0] grant;
      logic       valid;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req;
   logic [WIDTH-1:0] in0_data, in1_data, in2_data, in3_data;
   logic [3:0]       in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       grant;
   logic [1:0]       sel;

   int               total;
   int               passed;
   vec_t             vecs[$];
   logic [7:0]       sb[$];
   logic [5:0]       seq[4];
   int               split;

   mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in0_data  (in0_data),
      .in1_data  (in1_data),
      .in2_data  (in2_data),
      .in3_data  (in3_data),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant     (grant),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic [3:0] g, input logic v);
      vec_t x;
      x.req = r; x.rdy = rd; x.grant = g; x.valid = v;
      return x;
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] oh);
      case (oh)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive_data();
      in0_data = {2'd0, seq[0]};
      in1_data = {2'd1, seq[1]};
      in2_data = {2'd2, seq[2]};
      in3_data = {2'd3, seq[3]};
   endtask

   // One clock cycle: drive, check at negedge, return just after the next posedge.
   task automatic apply(input vec_t v, input int n);
      logic [1:0] i;
      logic [7:0] exp;
      req       = v.req;
      out_ready = v.rdy;
      drive_data();
      @(negedge clk);
      chk($sformatf("grant[%0d]", n), 32'(grant), 32'(v.grant));
      chk($sformatf("out_valid[%0d]", n), 32'(out_valid), 32'(v.valid));
      chk($sformatf("in_ready[%0d]", n), 32'(in_ready), 32'(v.grant & {4{v.rdy}}));
      if (v.grant != 4'b0000) chk($sformatf("sel[%0d]", n), 32'(sel), 32'(idx_of(v.grant)));
      else                    chk($sformatf("idle_data[%0d]", n), 32'(out_data), 32'd0);
      if (v.valid && v.rdy) begin
         i = idx_of(v.grant);
         sb.push_back({i, seq[i]});
         seq[i] = seq[i] + 6'd1;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_beat[%0d]: got data %0h expected no beat", n, out_data);
         end else begin
            exp = sb.pop_front();
            chk($sformatf("data[%0d]", n), 32'(out_data), 32'(exp));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      passed = 0;
      foreach (seq[k]) seq[k] = 6'd0;

      // Reset release, then fair rotation with all four requesting.
      vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 1'b0));
      for (int g = 0; g < 4; g++)
         for (int b = 0; b < 4; b++)
            vecs.push_back(mk(4'b1111, 1'b1, 4'(1 << g), 1'b1));
      vecs.push_back(mk(4'b1111, 1'b1, 4'b0001, 1'b1));
      // Sole requester is re-granted across burst boundaries with no bubble.
      for (int b = 0; b < 8; b++) vecs.push_back(mk(4'b0001, 1'b1, 4'b0001, 1'b1));
      vecs.push_back(mk(4'b0000, 1'b1, 4'b0001, 1'b0));
      vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0));
      // Backpressure on grant 0010: five stalled cycles, then a full burst of four.
      vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0));
      for (int b = 0; b < 5; b++) vecs.push_back(mk(4'b0010, 1'b0, 4'b0010, 1'b1));
      for (int b = 0; b < 4; b++) vecs.push_back(mk(4'b0110, 1'b1, 4'b0010, 1'b1));
      // Early drop by requester 2 after two beats hands over to requester 3.
      for (int b = 0; b < 2; b++) vecs.push_back(mk(4'b1100, 1'b1, 4'b0100, 1'b1));
      vecs.push_back(mk(4'b1000, 1'b1, 4'b0100, 1'b0));
      for (int b = 0; b < 5; b++) vecs.push_back(mk(4'b1000, 1'b1, 4'b1000, 1'b1));
      split = vecs.size();
      // After async reset: regrant of 3, full burst from cnt=0, then ptr=0 picks 0.
      vecs.push_back(mk(4'b1000, 1'b1, 4'b0000, 1'b0));
      for (int b = 0; b < 3; b++) vecs.push_back(mk(4'b1000, 1'b1, 4'b1000, 1'b1));
      vecs.push_back(mk(4'b1001, 1'b1, 4'b1000, 1'b1));
      vecs.push_back(mk(4'b1001, 1'b1, 4'b0001, 1'b1));

      clk       = 1'b0;
      rst_n     = 1'b0;
      req       = 4'b1111;
      out_ready = 1'b1;
      drive_data();
      #3;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int n = 0; n < split; n++) apply(vecs[n], n);

      // Reset asserted between edges while requester 3 is mid-burst.
      req       = 4'b1000;
      out_ready = 1'b1;
      drive_data();
      #2;
      chk("pre_arst_grant", 32'(grant), 32'b1000);
      chk("pre_arst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int n = split; n < vecs.size(); n++) apply(vecs[n], n);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit 4:1 multiplexer between four requesters and drives a single valid/ready output stream. It grants one requester at a time, holds the mux select stable for up to MAX_BURST accepted beats, and then rotates priority. It sits directly in front of the shared downstream consumer and owns the mux select.

## Interface
- WIDTH, 8, data width of each input and the output.
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..255.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-requester request; requester i holds req[i] high while it has data on in_data[i].
- in0_data..in3_data  in  WIDTH each  requester data.
- in_ready  out  4  per-requester beat-accepted strobe.
- out_data  out  WIDTH  muxed data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- grant  out  4  one-hot current grant; all-zero when idle.
- sel  out  2  current mux select (binary form of grant).

## Operation
- FSM states: IDLE, BUSY. Registers: state, sel, grant, ptr[1:0] (highest-priority index), cnt[7:0] (beats in current grant).
- Winner search: the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req!=0, load sel/grant with the winner, set cnt=0, go to BUSY. Otherwise stay, with grant=0.
- BUSY combinational outputs:
  - out_valid = req[sel].
  - out_data = in_data[sel].
  - in_ready = grant & {4{out_ready}}.
  - beat = out_valid & out_ready.
- BUSY, no release: on beat, cnt increments. Otherwise everything holds.
- Release condition: (beat && cnt==MAX_BURST-1) || !req[sel].
- On release:
  - ptr = sel+1 (mod 4).
  - Rescan using the current req vector and the new ptr.
  - If a winner exists, load it, set cnt=0, and stay in BUSY. This adds no bubble.
  - If there is no winner, go to IDLE with grant=0.
- A sole requester that exhausts its burst is re-granted immediately, because the scan wraps back to it.
- A requester dropping req while granted releases the grant that cycle, with no beat transferred.
- When grant=0, out_data is forced to 0 and out_valid=0.
- The grant never changes while out_valid=1 and out_ready=0, unless req[sel] drops.

## Timing
- Reset (async, immediate): state=IDLE, sel=0, grant=0, ptr=0, cnt=0. Outputs: out_valid=0, out_data=0, in_ready=0.
- Arbitration latency from IDLE: req rising in cycle N gives grant and out_valid in cycle N+1.
- Handover latency in BUSY: zero idle cycles. The new grant is valid in the cycle after the releasing beat.
- Throughput: one beat per cycle while out_ready=1 and the granted req is held.
- Simultaneous requests in the same cycle are resolved purely by ptr order.
- Reset asserted mid-burst: grant drops without a clock, and the in-flight beat is not counted. After release, arbitration restarts at ptr=0.

## Structure
- Package mux_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the N_REQ=4 constant;
  - a function rr_pick(req, ptr) returning {found, index}.
- Sub-module mux4_bus: purely combinational, parameterized WIDTH, 4:1 data mux driven by sel. It is instantiated once. The arbiter owns all sequential state.

## Test plan
- Reset: hold rst_n=0 with req=1111 → grant=0000, sel=0, out_valid=0, out_data=0. Release reset → grant=0001 one cycle later.
- Single requester: req=0001, out_ready=1, MAX_BURST=4 → grant=0001 continuously, cnt wraps 0..3, 8 beats in 8 cycles, no bubble.
- Fair rotation: req=1111, out_ready=1 from reset → grants 0001, 0010, 0100, 1000, 0001, each for exactly 4 beats, with in_ready matching the grant.
- Backpressure: grant=0010, out_ready=0 for 5 cycles → out_valid=1, in_ready=0000, cnt and grant unchanged. The beat completes on the first cycle out_ready=1.
- Early drop: grant=0100 after 2 beats, req[2] falls, req[3]=1 → next cycle grant=1000, cnt=0, and no beat is counted for requester 2 in the drop cycle.
- Async reset mid-burst: assert rst_n=0 between clock edges while grant=1000 → grant=0000 and out_valid=0 immediately. After release with req=1000, the grant returns one cycle later with cnt=0.
